// File: rtl/cam_tx.sv
// cam_tx: OV7670-style camera source. Reads RGB332 pixels from a frame buffer
// (1-cycle synchronous read), expands them to RGB565 and sends two bytes per
// pixel with vsync/href framing.
// Optional build macro CAM_TX_PATTERN_EN adds input pat_en, which selects an
// internal 8-bar colour pattern instead of RAM data.
module cam_tx #(
  parameter int AW          = 17,
  parameter int DW          = 8,
  parameter int H_ACT       = 160,
  parameter int V_ACT       = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
`ifdef CAM_TX_PATTERN_EN
  input  logic          pat_en,
`endif
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          vsync,
  output logic          href,
  output logic [7:0]    px_data,
  output logic          frame_done,
  output logic          busy
);

  localparam int LINE_LEN = 2*H_ACT + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VW       = $clog2(V_ACT + VSYNC_LINES + V_BACK + V_FRONT + 1);

  localparam logic [HW-1:0] HC_LAST = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HC_ACT  = HW'(2*H_ACT);
  localparam logic [HW-1:0] HC_PRE  = HW'(2*H_ACT - 1);
  localparam logic [VW-1:0] VS_LAST = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  // RGB332 -> RGB565 by bit replication.
  function automatic logic [15:0] rgb565(input logic [7:0] p);
    return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[1]};
  endfunction

  logic [2:0]    r_state, w_nstate;
  logic [HW-1:0] r_hc, w_nhc;
  logic [VW-1:0] r_vc, w_nvc, w_vlast;
  logic          w_line_end, w_done_next, w_addr_inc, w_addr_clr;
  logic [AW-1:0] r_addr;
  logic          r_vsync, r_href, r_done, r_busy;
  logic [7:0]    r_pix_lo;
  logic [7:0]    w_src;
  logic [15:0]   w_rgb;

  // Next-state / counter logic: hc runs every line, vc counts lines per state.
  always_comb begin
    w_line_end = (r_hc == HC_LAST);
    w_nstate   = r_state;
    w_nhc      = r_hc;
    w_nvc      = r_vc;
    case (r_state)
      S_VSYNC:  w_vlast = VS_LAST;
      S_VBACK:  w_vlast = VB_LAST;
      S_ACTIVE: w_vlast = VA_LAST;
      default:  w_vlast = VF_LAST;
    endcase
    if (r_state == S_IDLE) begin
      if (en) begin
        w_nstate = S_VSYNC;
        w_nhc    = '0;
        w_nvc    = '0;
      end
    end else begin
      w_nhc = w_line_end ? '0 : r_hc + HW'(1);
      if (w_line_end) begin
        if (r_vc == w_vlast) begin
          w_nvc = '0;
          case (r_state)
            S_VSYNC:  w_nstate = S_VBACK;
            S_VBACK:  w_nstate = S_ACTIVE;
            S_ACTIVE: w_nstate = S_VFRONT;
            default:  w_nstate = S_IDLE;
          endcase
        end else begin
          w_nvc = r_vc + VW'(1);
        end
      end
    end
  end

  // Frame ends on the last cycle of the last front-porch line.
  assign w_done_next = (w_nstate == S_VFRONT) && (w_nhc == HC_LAST) && (w_nvc == VF_LAST);
  // Address advances one cycle ahead of each byte0: on odd hc inside the line,
  // and on the last blank cycle when another active line follows.
  assign w_addr_inc  = ((w_nstate == S_ACTIVE) && (w_nhc < HC_PRE) && w_nhc[0]) ||
                       ((r_state == S_ACTIVE) && (r_vc != VA_LAST) && (w_nhc == HC_LAST));
  assign w_addr_clr  = (r_state == S_IDLE) && (w_nstate == S_VSYNC);

  // Control state and registered framing outputs, aligned with r_hc/r_vc.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hc    <= '0;
      r_vc    <= '0;
      r_addr  <= '0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_hc    <= w_nhc;
      r_vc    <= w_nvc;
      if (w_addr_clr)      r_addr <= '0;
      else if (w_addr_inc) r_addr <= r_addr + AW'(1);
      r_vsync <= (w_nstate == S_VSYNC);
      r_href  <= (w_nstate == S_ACTIVE) && (w_nhc < HC_ACT);
      r_done  <= w_done_next;
      r_busy  <= (w_nstate != S_IDLE);
    end
  end

`ifdef CAM_TX_PATTERN_EN
  logic r_pat;

  // Eight vertical bars across the active width.
  function automatic logic [7:0] bar_color(input logic [HW-1:0] hc);
    int x;
    x = int'(hc >> 1);
    case ((x * 8) / H_ACT)
      0:       return 8'hFF;
      1:       return 8'hFC;
      2:       return 8'h1F;
      3:       return 8'h1C;
      4:       return 8'hE3;
      5:       return 8'hE0;
      6:       return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  // Pattern select is latched once, as the frame starts.
  always_ff @(posedge pclk) begin
    if ((r_state == S_IDLE) && en) r_pat <= pat_en;
  end

  assign w_src = r_pat ? bar_color(r_hc) : mem_rd_data[7:0];
`else
  assign w_src = mem_rd_data[7:0];
`endif

  assign w_rgb = rgb565(w_src);

  // Byte0 comes straight from the RAM output register; keep byte1 for the next cycle.
  always_ff @(posedge pclk) begin
    if (r_href && !r_hc[0]) r_pix_lo <= w_rgb[7:0];
  end

  assign mem_rd_addr = r_addr;
  assign vsync       = r_vsync;
  assign href        = r_href;
  assign px_data     = r_href ? (r_hc[0] ? r_pix_lo : w_rgb[15:8]) : 8'd0;
  assign frame_done  = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_cam_tx.sv
// tb_cam_tx: self-checking bench for cam_tx. A cycle-level reference model
// derived from frame arithmetic is compared against every output each cycle,
// alongside table-driven byte checks and hand-written framing sequences.
module tb_cam_tx;
  localparam int AW = 17, HA = 160, VA = 4, HB = 16, VS = 3, VB = 2, VF = 2;
  localparam int LL = 2*HA + HB;
  localparam int FR = (VS + VB + VA + VF) * LL;
  localparam int NPIX = HA * VA;

  logic          pclk = 1'b0, rst = 1'b0, en = 1'b0, pat_en = 1'b0;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          vsync, href, frame_done, busy;
  logic [7:0]    px_data;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  logic [7:0] ram [0:1023];

  always #5 pclk = ~pclk;

  cam_tx #(.AW(AW), .DW(8), .H_ACT(HA), .V_ACT(VA), .H_BLANK(HB),
           .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .pclk(pclk), .rst(rst), .en(en),
`ifdef CAM_TX_PATTERN_EN
    .pat_en(pat_en),
`endif
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .vsync(vsync), .href(href), .px_data(px_data),
    .frame_done(frame_done), .busy(busy));

  // Frame buffer with one cycle of read latency.
  always @(posedge pclk) mem_rd_data <= ram[mem_rd_addr[9:0]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [7:0] p);
    int r, g, b;
    r = p / 32; g = (p / 4) % 8; b = p % 4;
    return 16'((r * 4 + r / 2) * 2048 + (g * 8 + g) * 32 + (b * 8 + b * 2 + b / 2));
  endfunction

  function automatic logic [7:0] bar_rgb(input int x);
    logic [7:0] c [8];
    c = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    return c[(x * 8) / HA];
  endfunction

  // Expected address: latest pixel whose window (byte0 cycle minus one) has opened.
  function automatic int exp_addr(input int t);
    int tt, l, h, r, k;
    tt = t + 1; l = tt / LL; h = tt % LL;
    if (l < VS + VB) return 0;
    r = l - (VS + VB);
    if (r >= VA) return NPIX - 1;
    k = h / 2;
    if (k > HA - 1) k = HA - 1;
    return r * HA + k;
  endfunction

  // Reference model: frame position only.
  bit m_busy = 1'b0, m_pat = 1'b0;
  int m_t = 0, m_hold = 0;
  always @(posedge pclk) begin
    if (!rst) begin
      m_busy <= 1'b0; m_t <= 0; m_hold <= 0;
    end else if (m_busy) begin
      if (m_t == FR - 1) begin m_busy <= 1'b0; m_hold <= exp_addr(FR - 1); end
      else m_t <= m_t + 1;
    end else if (en) begin
      m_busy <= 1'b1; m_t <= 0; m_pat <= pat_en;
    end
  end

  // Monitor counters and captured bytes.
  int vs_cyc = 0, pulses = 0, len_ok = 0, gap_ok = 0, done_cnt = 0;
  int run = 0, low = 0, bidx = 0, addr_done = -1;
  logic prev_href = 1'b0;
  logic [7:0] cap [0:2*NPIX-1];

  always @(negedge pclk) begin : mon
    int l, h, n;
    logic ev, eh, ed, eb;
    logic [7:0] epx, src;
    logic [15:0] w;
    int ea;
    if (chk_on) begin
      ev = 0; eh = 0; ed = 0; eb = 0; epx = 8'd0; ea = m_hold;
      if (m_busy) begin
        l = m_t / LL; h = m_t % LL;
        eb = 1; ev = (l < VS); ed = (m_t == FR - 1); ea = exp_addr(m_t);
        if (l >= VS + VB && l < VS + VB + VA && h < 2 * HA) begin
          eh = 1;
          n = (l - VS - VB) * HA + h / 2;
          src = m_pat ? bar_rgb(h / 2) : ram[n];
          w = to565(src);
          epx = (h % 2 == 1) ? w[7:0] : w[15:8];
        end
      end
      check("cycle", 64'({vsync, href, px_data, mem_rd_addr, frame_done, busy}),
                     64'({ev, eh, epx, AW'(ea), ed, eb}));
    end
    prev_href <= href;
    if (href) run <= prev_href ? run + 1 : 1;
    else low <= prev_href ? 1 : low + 1;
    if (!href && prev_href) begin
      pulses <= pulses + 1;
      if (run == 2 * HA) len_ok <= len_ok + 1;
    end
    if (href && !prev_href && low == HB) gap_ok <= gap_ok + 1;
    if (vsync) vs_cyc <= vs_cyc + 1;
    if (frame_done) begin done_cnt <= done_cnt + 1; addr_done <= int'(mem_rd_addr); end
    if (vsync) bidx <= 0;
    else if (href && bidx < 2 * NPIX) begin cap[bidx] <= px_data; bidx <= bidx + 1; end
  end

  typedef struct { logic [7:0] word; logic [15:0] exp; } vec_t;
  typedef struct { int pix; logic [15:0] exp; } pvec_t;
  vec_t  tbl  [6];
  pvec_t ptbl [3];
  int s_vs, s_pulse, s_len, s_gap, s_done;

  task automatic snap();
    s_vs = vs_cyc; s_pulse = pulses; s_len = len_ok; s_gap = gap_ok; s_done = done_cnt;
  endtask

  task automatic pulse_en();
    @(posedge pclk); #2 en = 1'b1;
    @(posedge pclk); #2 en = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (k < FR + LL) begin
      @(negedge pclk);
      if (frame_done) break;
      k++;
    end
    check(nm, 64'(frame_done), 64'(1));
    @(posedge pclk); #2;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hE0, 16'hF800}; tbl[1] = '{8'h1C, 16'h07E0}; tbl[2] = '{8'h03, 16'h001F};
    tbl[3] = '{8'h92, 16'h9495}; tbl[4] = '{8'hFF, 16'hFFFF}; tbl[5] = '{8'h00, 16'h0000};
    ptbl[0] = '{0, 16'hFFFF}; ptbl[1] = '{20, 16'hFFE0}; ptbl[2] = '{159, 16'h0000};
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);

    // Power-on reset
    repeat (3) @(posedge pclk);
    #2 rst = 1'b1; chk_on = 1'b1;
    @(negedge pclk);
    check("reset_state", 64'({vsync, href, px_data, mem_rd_addr, frame_done, busy}), 64'(0));

    // Known RAM words, full-frame framing counts
    for (int i = 0; i < 6; i++) ram[i] = tbl[i].word;
    snap();
    pulse_en();
    wait_done("t2_done");
    check("t2_vsync_cycles", 64'(vs_cyc - s_vs), 64'(VS * LL));
    check("t2_href_pulses", 64'(pulses - s_pulse), 64'(VA));
    check("t2_href_len", 64'(len_ok - s_len), 64'(VA));
    check("t2_href_gaps", 64'(gap_ok - s_gap), 64'(VA - 1));
    check("t2_done_count", 64'(done_cnt - s_done), 64'(1));
    check("t2_last_addr", 64'(addr_done), 64'(NPIX - 1));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_byte0_px%0d", i), 64'(cap[2*i]), 64'(tbl[i].exp[15:8]));
      check($sformatf("t3_byte1_px%0d", i), 64'(cap[2*i+1]), 64'(tbl[i].exp[7:0]));
    end
    repeat (20) @(posedge pclk);
    #2 check("t2_back_idle", 64'(busy), 64'(0));

    // Reset in the middle of the active region
    begin
      int k;
      pulse_en();
      k = 0;
      while (!href && k < FR) begin @(negedge pclk); k++; end
      check("t1_reach_active", 64'(href), 64'(1));
      repeat (7) @(posedge pclk);
      #2 rst = 1'b0;
      @(posedge pclk); @(negedge pclk);
      check("t1_reset_outputs", 64'({vsync, href, px_data, mem_rd_addr, busy}), 64'(0));
      @(posedge pclk); @(posedge pclk);
      #2 rst = 1'b1; en = 1'b0;
      s_done = done_cnt;
      repeat (50) @(posedge pclk);
      #2 check("t1_stays_idle", 64'({busy, vsync}), 64'(0));
      check("t1_no_done", 64'(done_cnt - s_done), 64'(0));
    end

    // Data equals address low byte
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    pulse_en();
    wait_done("t4_done");
    check("t4_last_addr", 64'(addr_done), 64'(NPIX - 1));

    // Back-to-back frames, en dropped during frame 2
    begin
      int k;
      snap();
      @(posedge pclk); #2 en = 1'b1;
      k = 0;
      while (!vsync && k < 10) begin @(negedge pclk); k++; end
      check("t4_addr_at_vsync", 64'(mem_rd_addr), 64'(0));
      wait_done("t5_done_a");
      k = 0;
      while (!vsync && k < 10) begin @(negedge pclk); k++; end
      check("t5_frame2_start", 64'(vsync), 64'(1));
      repeat (500) @(posedge pclk);
      #2 en = 1'b0;
      wait_done("t5_done_b");
      check("t5_href_pulses", 64'(pulses - s_pulse), 64'(2 * VA));
      check("t5_href_len", 64'(len_ok - s_len), 64'(2 * VA));
      repeat (2 * LL) @(posedge pclk);
      #2 check("t5_no_third", 64'({busy, vsync}), 64'(0));
      check("t5_done_count", 64'(done_cnt - s_done), 64'(2));
    end

    // Random RAM contents and start timing
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
      repeat ($urandom_range(1, 20)) @(posedge pclk);
      #2 en = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge pclk);
      #2 en = 1'b0;
      wait_done($sformatf("rand_done_%0d", it));
    end

`ifdef CAM_TX_PATTERN_EN
    // Colour bars; pat_en changes after frame start must be ignored
    pat_en = 1'b1;
    pulse_en();
    repeat (5) @(posedge pclk);
    #2 pat_en = 1'b0;
    wait_done("t6_done");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_byte0_px%0d", ptbl[i].pix), 64'(cap[2*ptbl[i].pix]), 64'(ptbl[i].exp[15:8]));
      check($sformatf("t6_byte1_px%0d", ptbl[i].pix), 64'(cap[2*ptbl[i].pix+1]), 64'(ptbl[i].exp[7:0]));
    end
`endif

    repeat (5) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_tx.md
Name: cam_tx

Overview:
- Synthesizable OV7670-style camera transmitter, i.e. the source end of the vsync/href/px_data capture interface.
- Reads RGB332 pixels from a frame-buffer RAM (1-cycle synchronous read), expands each to RGB565 and emits two bytes per pixel with camera-accurate vsync/href framing.
- Drives the capture path and frame buffer in simulation and on-board loopback, without a physical sensor.

Parameters:
- AW, 17: read-address width.
- DW, 8: RAM data width (RGB332).
- H_ACT, 160: active pixels per line (each pixel is 2 pclk cycles).
- V_ACT, 120: active lines per frame.
- H_BLANK, 16: href-low cycles after each line's active portion.
- VSYNC_LINES, 3: lines with vsync high.
- V_BACK, 2: blank lines after vsync, before the first active line.
- V_FRONT, 2: blank lines after the last active line.

Ports:
- pclk  in  1  sole clock; all outputs change on rising edge only.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on posedge pclk.
- en  in  1  frame enable; sampled only in IDLE.
- mem_rd_addr  out  AW  frame-buffer read address, row-major pixel index.
- mem_rd_data  in  DW  RGB332 {R[2:0],G[2:0],B[1:0]}, valid 1 cycle after address.
- vsync  out  1  frame sync, active high.
- href  out  1  line-valid; high exactly during active byte cycles.
- px_data  out  8  RGB565 byte stream, high byte first.
- frame_done  out  1  single-cycle pulse at frame end.
- busy  out  1  high from frame start through frame_done cycle.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, all counters 0; vsync=0, href=0, px_data=0, mem_rd_addr=0, frame_done=0, busy=0. Reset mid-frame aborts the frame immediately; no frame_done.
- LINE_LEN = 2*H_ACT + H_BLANK cycles. hc counts 0..LINE_LEN-1, vc counts lines within a state.
- FSM transitions:
  - IDLE -> VSYNC when en=1.
  - VSYNC: vsync=1 for VSYNC_LINES*LINE_LEN cycles -> VBACK.
  - VBACK: V_BACK lines -> ACTIVE.
  - ACTIVE: V_ACT lines; href=1 for hc<2*H_ACT, else 0 -> VFRONT.
  - VFRONT: V_FRONT lines; frame_done=1 on its last cycle -> IDLE.
- en is ignored outside IDLE. Dropping en mid-frame completes the frame. en held high gives back-to-back frames, with one IDLE cycle between frames.
- Byte order: for pixel k, byte0 at hc=2k, byte1 at hc=2k+1.
  - RGB565 = {R,R[2:1], G,G, B,B,B[1]}; byte0 = RGB565[15:8], byte1 = RGB565[7:0].
- px_data = 0 whenever href=0. Outputs are registered; href and px_data are cycle-aligned.
- Read timing:
  - Address of pixel n is stable on mem_rd_addr the cycle before its byte0 and is held through byte0.
  - For the first pixel of a line, that cycle is the last blank cycle of the preceding line.
  - The RAM word is captured at byte0 and held internally for byte1.
- Address range: mem_rd_addr runs 0..H_ACT*V_ACT-1 with no wrap inside a frame. It returns to 0 on entering VSYNC and holds its last value during blanking otherwise.
- Reset during ACTIVE forces href=0 and px_data=0 on the same edge.

Optional Feature:
- Macro CAM_TX_PATTERN_EN.
- Defined:
  - Adds input port pat_en (1 bit).
  - When pat_en=1, the pixel source is 8 vertical colour bars; bar index = (pixel_x*8)/H_ACT, giving RGB332 values in order 0xFF,0xFC,0x1F,0x1C,0xE3,0xE0,0x03,0x00.
  - mem_rd_addr still sequences normally; mem_rd_data is ignored.
  - pat_en is sampled only at frame start.
- Undefined: pat_en does not exist; the source is always RAM.

Test Plan:
1. rst=0 for 3 cycles mid-ACTIVE, then rst=1, en=0 -> next edge href=0, vsync=0, px_data=0, addr=0, busy=0; block stays IDLE.
2. en pulsed 1 cycle, default params -> vsync high exactly 3*336 cycles; 120 href pulses of 320 cycles each, separated by 16 low cycles; one frame_done; then IDLE.
3. RAM words 0xE0, 0x1C, 0x03, 0x92, 0xFF, 0x00 at addresses 0..5 -> px_data bytes F8 00, 07 E0, 00 1F, 94 95, FF FF, 00 00.
4. 1-cycle-latency RAM model returning data = addr[7:0] -> every pixel byte pair matches the expansion of its index; last address 19199; mem_rd_addr=0 at next vsync.
5. en held 1 for 2 frames with en dropped during frame 2 -> frame 2 completes with full line count; 2 frame_done pulses; no third frame.
6. With CAM_TX_PATTERN_EN defined and pat_en=1 -> pixel 0 bytes FF FF, pixel 20 (bar 1, 0xFC) bytes FF E0, pixel 159 (bar 7, 0x00) bytes 00 00.
